// File: rtl/l2_stream_prefetcher.sv
// l2_stream_prefetcher
//
// Next-line stream prefetch buffer between the L2 cache controller and
// physical memory. A read miss for line A fetches A from pmem and restarts
// the stream at A+1; while idle, the block prefetches up to DEPTH following
// lines into a FIFO of line buffers. A later L2 read that matches the valid
// FIFO head is answered from the buffer in one cycle. Writebacks go straight
// to pmem and invalidate any buffered copy of the written line.
//
// Parameters:
//   ADDR_W  byte address width
//   LINE_W  line width in bits
//   OFF_W   line offset bits (line address is ADDR_W-OFF_W bits)
//   DEPTH   buffer entries, power of two, >= 2
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   mem_read, mem_write   L2 requests, held until mem_resp
//   mem_address           request address (offset bits ignored)
//   mem_wdata             writeback line
//   mem_rdata, mem_resp   returned line and one-cycle completion pulse
//   pmem_read, pmem_write pmem strobes, held until pmem_resp
//   pmem_address          line-aligned pmem address
//   pmem_wdata            line written to pmem
//   pmem_rdata, pmem_resp pmem read data and completion
//
// Build option:
//   L2_PF_STATS_EN        adds pf_hit_count / pf_miss_count (16-bit,
//                         saturating) counting buffer hits and demand misses.

module l2_stream_prefetcher #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned OFF_W  = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
`ifdef L2_PF_STATS_EN
  ,
  output logic [15:0]       pf_hit_count,
  output logic [15:0]       pf_miss_count
`endif
);

  localparam int unsigned LA_W  = ADDR_W - OFF_W;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_DEMAND,
    S_PREFETCH,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [LA_W-1:0]     line_q [DEPTH];
  logic [LA_W-1:0]     line_d [DEPTH];
  logic [LINE_W-1:0]   data_q [DEPTH];
  logic [LINE_W-1:0]   data_d [DEPTH];
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [LA_W-1:0]     pf_next_q, pf_next_d;
  logic                active_q, active_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic                pread_q, pread_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [LINE_W-1:0]   pwdata_q, pwdata_d;

  logic [LA_W-1:0]     req_line;
  logic [OFF_W-1:0]    unused_offset;
  logic                head_hit;
  logic                hit_evt;
  logic                miss_evt;

  assign req_line      = mem_address[ADDR_W-1:OFF_W];
  assign unused_offset = mem_address[OFF_W-1:0];

  // Only the head may satisfy a read; a match deeper in the FIFO means the
  // stream was skipped ahead, which is treated as a miss and restarts it.
  assign head_hit = valid_q[head_q] && (line_q[head_q] == req_line);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    line_d    = line_q;
    data_d    = data_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    pf_next_d = pf_next_q;
    active_d  = active_q;
    rdata_d   = rdata_q;
    pread_d   = pread_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    hit_evt   = 1'b0;
    miss_evt  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (mem_write) begin
          // Invalidated entries keep their FIFO slot; a later read reaching
          // an invalid head simply misses and flushes the buffer.
          for (int unsigned i = 0; i < DEPTH; i++) begin
            if (line_q[PTR_W'(i)] == req_line) begin
              valid_d[PTR_W'(i)] = 1'b0;
            end
          end
          pwrite_d = 1'b1;
          paddr_d  = {req_line, {OFF_W{1'b0}}};
          pwdata_d = mem_wdata;
          state_d  = S_WRITE;
        end else if (mem_read) begin
          if (head_hit) begin
            rdata_d          = data_q[head_q];
            valid_d[head_q]  = 1'b0;
            head_d           = head_q + 1'b1;
            count_d          = count_q - 1'b1;
            hit_evt          = 1'b1;
            state_d          = S_RESP;
          end else begin
            valid_d   = '0;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            pf_next_d = req_line + 1'b1;
            pread_d   = 1'b1;
            paddr_d   = {req_line, {OFF_W{1'b0}}};
            miss_evt  = 1'b1;
            state_d   = S_DEMAND;
          end
        end else if (active_q && (count_q < CNT_W'(DEPTH))) begin
          pread_d = 1'b1;
          paddr_d = {pf_next_q, {OFF_W{1'b0}}};
          state_d = S_PREFETCH;
        end
      end

      S_WRITE: begin
        if (pmem_resp) begin
          pwrite_d = 1'b0;
          state_d  = S_RESP;
        end
      end

      S_DEMAND: begin
        if (pmem_resp) begin
          pread_d  = 1'b0;
          rdata_d  = pmem_rdata;
          active_d = 1'b1;
          state_d  = S_RESP;
        end
      end

      S_PREFETCH: begin
        if (pmem_resp) begin
          pread_d         = 1'b0;
          valid_d[tail_q] = 1'b1;
          line_d[tail_q]  = pf_next_q;
          data_d[tail_q]  = pmem_rdata;
          tail_d          = tail_q + 1'b1;
          count_d         = count_q + 1'b1;
          pf_next_d       = pf_next_q + 1'b1;
          state_d         = S_IDLE;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      valid_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pf_next_q <= '0;
      active_q  <= 1'b0;
      rdata_q   <= '0;
      pread_q   <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      pf_next_q <= pf_next_d;
      active_q  <= active_d;
      rdata_q   <= rdata_d;
      pread_q   <= pread_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  // Line storage needs no reset: entries are only consumed when valid.
  always_ff @(posedge clk) begin
    line_q <= line_d;
    data_q <= data_d;
  end

  assign mem_resp     = (state_q == S_RESP);
  assign mem_rdata    = rdata_q;
  assign pmem_read    = pread_q;
  assign pmem_write   = pwrite_q;
  assign pmem_address = paddr_q;
  assign pmem_wdata   = pwdata_q;

`ifdef L2_PF_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (miss_evt && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign pf_hit_count  = hit_cnt_q;
  assign pf_miss_count = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_l2_stream_prefetcher.sv
// tb_l2_stream_prefetcher
//
// Directed and randomized stimulus for l2_stream_prefetcher. A responder
// process plays pmem with random latency and logs every pmem transaction;
// the main sequence predicts that log, the returned data and the response
// latency from a line-level model of the stream buffer (queue of buffered
// line numbers, next-line pointer, stream-active flag, memory contents).

module tb_l2_stream_prefetcher;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  localparam int OFF_W  = 4;
  localparam int DEPTH  = 4;
  localparam int NLINES = 4096;

  logic              clk;
  logic              reset;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
`ifdef L2_PF_STATS_EN
  logic [15:0]       pf_hit_count;
  logic [15:0]       pf_miss_count;
`endif

  l2_stream_prefetcher #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W),
    .OFF_W (OFF_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
`ifdef L2_PF_STATS_EN
    ,
    .pf_hit_count (pf_hit_count),
    .pf_miss_count(pf_miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [127:0] wd;
  } txn_t;

  int   checks = 0;
  int   errors = 0;

  txn_t log_q[$];
  int   log_rd = 0;
  txn_t exp_q[$];
  int   resp_cyc = 0;
  bit   hold = 1'b0;

  // Line-level model state
  int unsigned  mbuf_line[$];
  bit           mbuf_valid[$];
  bit           m_active;
  int unsigned  m_pfnext;
  int           m_hits;
  int           m_misses;
  logic [127:0] mmem[int unsigned];

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] line_init(int unsigned line);
    logic [31:0] l;
    l = line;
    return {l * 32'h9E3779B1, l ^ 32'h5A5A1234, ~l, l * 32'h01000193 + 32'd7};
  endfunction

  function automatic logic [127:0] mdata(int unsigned line);
    return mmem.exists(line) ? mmem[line] : line_init(line);
  endfunction

  function automatic txn_t mk(bit wr, int unsigned line, logic [127:0] wd);
    txn_t t;
    t.wr   = wr;
    t.addr = 16'(line << 4);
    t.wd   = wd;
    return t;
  endfunction

  // pmem responder: logs each request, answers after 1..4 cycles.
  logic [127:0] store[int unsigned];
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (!reset && (pmem_read || pmem_write)) begin
        txn_t t;
        int   lat;
        chk("pmem_exclusive", pmem_read & pmem_write, 0);
        t.wr   = pmem_write;
        t.addr = pmem_address;
        t.wd   = pmem_write ? pmem_wdata : '0;
        log_q.push_back(t);
        lat = $urandom_range(0, 3);
        repeat (lat) begin
          @(negedge clk);
          if (!hold && !reset) chk("pmem_addr_stable", pmem_address, t.addr);
        end
        while (hold) @(negedge clk);
        if (t.wr) begin
          store[int'(t.addr >> 4)] = t.wd;
        end else begin
          pmem_rdata = store.exists(int'(t.addr >> 4)) ? store[int'(t.addr >> 4)]
                                                      : line_init(int'(t.addr >> 4));
        end
        pmem_resp = 1'b1;
        resp_cyc  = cyc;
        @(negedge clk);
        pmem_resp = 1'b0;
      end
    end
  end

  task automatic model_reset();
    mbuf_line.delete();
    mbuf_valid.delete();
    m_active = 1'b0;
    m_pfnext = 0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_settle();
    while (m_active && mbuf_line.size() < DEPTH) begin
      exp_q.push_back(mk(1'b0, m_pfnext, '0));
      mbuf_line.push_back(m_pfnext);
      mbuf_valid.push_back(1'b1);
      m_pfnext = (m_pfnext + 1) % NLINES;
    end
  endtask

  task automatic compare_log(string tag);
    int n;
    repeat (60) @(negedge clk);
    chk({tag, "_quiet"}, pmem_read | pmem_write, 0);
    n = log_q.size() - log_rd;
    chk({tag, "_pmem_count"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      chk({tag, "_pmem_wr"}, log_q[log_rd + i].wr, exp_q[i].wr);
      chk({tag, "_pmem_addr"}, log_q[log_rd + i].addr, exp_q[i].addr);
      if (exp_q[i].wr) chk({tag, "_pmem_wdata"}, log_q[log_rd + i].wd, exp_q[i].wd);
    end
    log_rd = log_q.size();
    exp_q.delete();
  endtask

  task automatic do_read(logic [15:0] addr);
    int unsigned  l;
    bit           hit;
    logic [127:0] ed;
    int           n;
    l   = int'(addr >> 4);
    hit = (mbuf_line.size() > 0) && mbuf_valid[0] && (mbuf_line[0] == l);
    if (hit) begin
      void'(mbuf_line.pop_front());
      void'(mbuf_valid.pop_front());
      m_hits++;
    end else begin
      exp_q.push_back(mk(1'b0, l, '0));
      mbuf_line.delete();
      mbuf_valid.delete();
      m_pfnext = (l + 1) % NLINES;
      m_active = 1'b1;
      m_misses++;
    end
    ed = mdata(l);
    mem_read    = 1'b1;
    mem_address = addr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_resp && n < 200);
    chk("read_resp_seen", mem_resp, 1);
    if (hit) chk("hit_latency", n, 1);
    else     chk("miss_resp_after_pmem", cyc, resp_cyc + 1);
    chk("read_data", mem_rdata, ed);
    mem_read = 1'b0;
    model_settle();
    compare_log(hit ? "hit" : "miss");
  endtask

  task automatic do_write(logic [15:0] addr, logic [127:0] w);
    int unsigned l;
    int          n;
    l = int'(addr >> 4);
    foreach (mbuf_line[i]) if (mbuf_line[i] == l) mbuf_valid[i] = 1'b0;
    mmem[l] = w;
    exp_q.push_back(mk(1'b1, l, w));
    mem_write   = 1'b1;
    mem_address = addr;
    mem_wdata   = w;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_resp && n < 200);
    chk("write_resp_seen", mem_resp, 1);
    chk("write_resp_after_pmem", cyc, resp_cyc + 1);
    mem_write = 1'b0;
    model_settle();
    compare_log("write");
  endtask

  initial begin
    bit seen;
    reset       = 1'b1;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_mem_resp", mem_resp, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_pmem_address", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_no_prefetch", pmem_read, 0);

    // Directed sequence
    do_read(16'h1230);             // miss, prefetch 0x1240..0x1270
    do_read(16'h1240);             // hit, prefetch 0x1280
    do_read(16'h5000);             // flush, demand, prefetch from 0x5010
    do_read(16'hFFF0);             // prefetch wraps to 0x0000
    do_read(16'h0000);             // hit on wrapped line
    do_read(16'h1240);             // miss, buffer 0x1250..0x1280
    do_write(16'h1250, {4{32'hC0FFEE11}});
    do_read(16'h1250);             // invalidated head -> miss to pmem
    do_read(16'h1268);             // offset bits ignored, head hit

    // Randomized mix of sequential, random, non-head reads and writes
    for (int k = 0; k < 40; k++) begin
      int unsigned r;
      int unsigned off;
      r   = $urandom_range(0, 9);
      off = $urandom_range(0, 15);
      if (r < 5 && mbuf_line.size() > 0) begin
        do_read(16'((mbuf_line[0] << 4) | off));
      end else if (r < 7) begin
        do_read(16'(($urandom_range(0, NLINES - 1) << 4) | off));
      end else if (r < 9) begin
        int unsigned wl;
        wl = (mbuf_line.size() > 0) ? mbuf_line[$urandom_range(0, mbuf_line.size() - 1)]
                                    : $urandom_range(0, NLINES - 1);
        do_write(16'((wl << 4) | off), {$urandom, $urandom, $urandom, $urandom});
      end else begin
        if (mbuf_line.size() > 1) do_read(16'(mbuf_line[mbuf_line.size() - 1] << 4));
        else                      do_read(16'h2220);
      end
    end

`ifdef L2_PF_STATS_EN
    chk("stat_hits", pf_hit_count, m_hits);
    chk("stat_misses", pf_miss_count, m_misses);
`endif

    // Reset while a demand read is outstanding; the late pmem_resp is ignored.
    hold        = 1'b1;
    mem_read    = 1'b1;
    mem_address = 16'(((((mbuf_line.size() > 0) ? mbuf_line[0] : 0) + 7) % NLINES) << 4);
    repeat (3) @(negedge clk);
    chk("pre_rst_strobe", pmem_read, 1);
    reset    = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    chk("midrst_pmem_read", pmem_read, 0);
    chk("midrst_pmem_write", pmem_write, 0);
    chk("midrst_mem_resp", mem_resp, 0);
    chk("midrst_pmem_address", pmem_address, 0);
    chk("midrst_mem_rdata", mem_rdata, 0);
`ifdef L2_PF_STATS_EN
    chk("midrst_stat_hits", pf_hit_count, 0);
    chk("midrst_stat_misses", pf_miss_count, 0);
`endif
    reset = 1'b0;
    model_reset();
    log_rd = log_q.size();
    hold   = 1'b0;
    seen   = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (mem_resp || pmem_read || pmem_write) seen = 1'b1;
    end
    chk("stale_resp_ignored", seen, 0);
    compare_log("post_rst");
    do_read(16'h1230);
    do_read(16'h1240);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_stream_prefetcher.md
# l2_stream_prefetcher

Parametrised next-line stream prefetch buffer between the L2 cache controller and physical memory. A read miss for line A fetches A from pmem, then fetches A+1 … A+DEPTH in the background into a FIFO of line buffers. Subsequent sequential L2 misses are served from the buffer head without a pmem round trip. Writebacks pass straight through and invalidate any matching buffered line.

## Interface
- `ADDR_W`, 16, byte address width.
- `LINE_W`, 128, line width in bits.
- `OFF_W`, 4, line offset bits; line address is `ADDR_W-OFF_W` bits.
- `DEPTH`, 4, buffer entries; power of two, ≥2.
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `mem_read` in 1 — L2 line read request; held until `mem_resp`.
- `mem_write` in 1 — L2 writeback request; held until `mem_resp`.
- `mem_address` in ADDR_W — request address; low OFF_W bits ignored.
- `mem_wdata` in LINE_W — writeback line.
- `mem_rdata` out LINE_W — returned line; valid while `mem_resp`.
- `mem_resp` out 1 — one-cycle completion pulse.
- `pmem_read`, `pmem_write` out 1 — held until `pmem_resp`.
- `pmem_address` out ADDR_W — always line-aligned (low OFF_W bits 0).
- `pmem_wdata` out LINE_W; `pmem_rdata` in LINE_W; `pmem_resp` in 1.

## Operation
- Entry: valid bit, line address, line data. FIFO with head/tail pointers and an occupancy count of 0..DEPTH; `pf_next` holds the next line address to prefetch.
- States: IDLE, WRITE, DEMAND, PREFETCH, RESP.
- IDLE, priority order:
  - `mem_write` → invalidate every entry whose line address matches; → WRITE. `mem_read` and `mem_write` together is illegal; write wins.
  - `mem_read` with head valid and matching → latch head data, pop head → RESP.
  - `mem_read` otherwise (miss, including a match at a non-head entry) → flush all entries, `pf_next` = line+1 → DEMAND.
  - No request, count < DEPTH, stream active → PREFETCH.
- WRITE: drive `pmem_write` with `mem_address` and `mem_wdata`. On `pmem_resp` → RESP. If the written line equals `pf_next`, nothing is affected. Buffered copies are already invalidated.
- DEMAND: `pmem_read` of the requested line. On `pmem_resp`, latch the data and mark the stream active → RESP. The demand line is not buffered.
- PREFETCH: `pmem_read` at `pf_next`. On `pmem_resp`, push the line at the tail, `pf_next`+1 → IDLE. Returning to IDLE between prefetches gives demand requests priority.
- RESP: `mem_resp`=1 for one cycle with the latched data (`mem_rdata` is don't-care for writes). Requests are not sampled → IDLE.
- Line address arithmetic is modulo 2^(ADDR_W-OFF_W). Line 0xFFF (address 0xFFF0) is followed by 0x000.
- Stream goes inactive on reset only. After the first demand miss the buffer refills after every pop.

## Timing
- Reset: all entries invalid, count 0, head/tail 0, stream inactive, state IDLE. `mem_resp`, `pmem_read`, `pmem_write` = 0. `mem_rdata`, `pmem_address`, `pmem_wdata` = 0.
- Reset mid-transaction: pmem strobes drop in the same edge. A stale `pmem_resp` seen in IDLE is ignored.
- Buffer hit: `mem_read` sampled at edge t; `mem_resp` high in cycle t+1. Latency 1.
- Miss or write: `pmem_*` asserted in cycle t+1. If `pmem_resp` arrives in cycle p, `mem_resp` is high in cycle p+1.
- A request arriving while a prefetch is outstanding waits for that `pmem_resp` plus one cycle before it is sampled.
- Full (count = DEPTH): no prefetch is issued. Pop and push never coincide.
- `pmem_read` and `pmem_write` are never high together. `pmem_address` is stable while either strobe is high.

## Configuration
- `L2_PF_STATS_EN` defined:
  - Adds outputs `pf_hit_count` and `pf_miss_count`, each 16 bits.
  - They count buffer hits and demand misses, saturate at 0xFFFF, and clear on `reset`.
- Not defined: the ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset, then read 0x1230 (pmem returns D0 after 3 cycles) → `mem_rdata`=D0. pmem then prefetches 0x1240, 0x1250, 0x1260, 0x1270 and stops at count 4.
- After the fill, read 0x1240 → `mem_resp` one cycle after the sample, no `pmem_read`. Next `pmem_address` is 0x1280.
- With the buffer full from 0x1240, read 0x5000 → buffer flushed, demand fetch of 0x5000, then prefetch from 0x5010.
- Read 0xFFF0 → prefetch addresses are 0x0000, 0x0010, … (wrap). Then read 0x0000 → buffer hit.
- With 0x1250 buffered, write 0x1250 with W → `pmem_write` at 0x1250 with W. A later read of 0x1250 misses and goes to pmem.
- Assert `reset` while `pmem_read` is high → strobes are 0 the next cycle and a late `pmem_resp` is ignored. With `L2_PF_STATS_EN`, both counters read 0.
